// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and the 8-bit datapath.
// The master side is the controller and the slave side is the datapath.
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       opcode;
    logic [2:0]       funct;
    logic             flagz;
    logic             mem_ready;

    logic [2:0]       ula_control;
    logic             alu_src_b;
    logic             ir_write;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, flagz, mem_ready,
        output ula_control, alu_src_b, ir_write, pc_en, pc_src,
               mem_read, mem_write, reg_write, mem_to_reg, reg_dst,
               halted, illegal, instr_count
    );

    modport slave (
        output opcode, funct, flagz, mem_ready,
        input  ula_control, alu_src_b, ir_write, pc_en, pc_src,
               mem_read, mem_write, reg_write, mem_to_reg, reg_dst,
               halted, illegal, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback
// for the 8-bit datapath and counts retired instructions.
//
// state    | meaning
// FETCH    | read instruction memory, load IR and PC+1 on mem_ready
// DECODE   | latch opcode/funct, dispatch or flag illegal
// EXEC     | R-type / addi ALU operation
// WB_ALU   | write ALU result to rd (R-type) or rt (addi)
// ADDR     | compute lw/sw effective address
// MEM_RD   | data memory read, wait for mem_ready
// WB_MEM   | write loaded data to rt
// MEM_WR   | data memory write, wait for mem_ready
// BRANCH   | beq compare, PC update when flagz
// JUMP     | PC <- jump target
// HALT     | idle until reset
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB_ALU,
        S_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_J    = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [2:0]       r_funct;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    logic             w_funct_ok;
    logic [2:0]       w_ula;
    logic             w_srcb;
    logic             w_irw;
    logic             w_pcen;
    logic [1:0]       w_pcsrc;
    logic             w_mrd;
    logic             w_mwr;
    logic             w_rw;
    logic             w_m2r;
    logic             w_rdst;
    logic             w_halted;

    always_comb begin
        case (bus.funct)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: w_funct_ok = 1'b1;
            default:                                w_funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_op      <= 3'b000;
            r_funct   <= 3'b000;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.mem_ready) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_op    <= bus.opcode;
                    r_funct <= bus.funct;
                    case (bus.opcode)
                        OP_R: begin
                            if (w_funct_ok) begin
                                r_state <= S_EXEC;
                            end else begin
                                r_illegal <= 1'b1;
                                r_state   <= S_HALT;
                            end
                        end
                        OP_ADDI:        r_state <= S_EXEC;
                        OP_LW, OP_SW:   r_state <= S_ADDR;
                        OP_BEQ:         r_state <= S_BRANCH;
                        OP_J:           r_state <= S_JUMP;
                        OP_HALT:        r_state <= S_HALT;
                        default: begin
                            r_illegal <= 1'b1;
                            r_state   <= S_HALT;
                        end
                    endcase
                end
                S_EXEC:   r_state <= S_WB_ALU;
                S_ADDR:   r_state <= (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (bus.mem_ready) r_state <= S_WB_MEM;
                end
                S_MEM_WR: begin
                    if (bus.mem_ready) begin
                        r_state <= S_FETCH;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: begin
                    r_state <= S_FETCH;
                    r_cnt   <= r_cnt + 1'b1;
                end
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode from state and latched op/funct; only FETCH (mem_ready)
    // and BRANCH (flagz) look at live inputs.
    always_comb begin
        w_ula    = ALU_ADD;
        w_srcb   = 1'b0;
        w_irw    = 1'b0;
        w_pcen   = 1'b0;
        w_pcsrc  = 2'b00;
        w_mrd    = 1'b0;
        w_mwr    = 1'b0;
        w_rw     = 1'b0;
        w_m2r    = 1'b0;
        w_rdst   = 1'b0;
        w_halted = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mrd  = 1'b1;
                w_irw  = bus.mem_ready;
                w_pcen = bus.mem_ready;
            end
            S_EXEC: begin
                w_ula  = (r_op == OP_R) ? r_funct : ALU_ADD;
                w_srcb = (r_op != OP_R);
            end
            S_WB_ALU: begin
                w_ula  = (r_op == OP_R) ? r_funct : ALU_ADD;
                w_srcb = (r_op != OP_R);
                w_rw   = 1'b1;
                w_rdst = (r_op == OP_R);
            end
            S_ADDR: begin
                w_srcb = 1'b1;
            end
            S_MEM_RD: begin
                w_srcb = 1'b1;
                w_mrd  = 1'b1;
            end
            S_WB_MEM: begin
                w_rw  = 1'b1;
                w_m2r = 1'b1;
            end
            S_MEM_WR: begin
                w_srcb = 1'b1;
                w_mwr  = 1'b1;
            end
            S_BRANCH: begin
                w_ula   = ALU_SUB;
                w_pcsrc = 2'b01;
                w_pcen  = bus.flagz;
            end
            S_JUMP: begin
                w_pcen  = 1'b1;
                w_pcsrc = 2'b10;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_halted = 1'b0;
            end
        endcase
    end

    assign bus.ula_control = w_ula;
    assign bus.alu_src_b   = w_srcb;
    assign bus.ir_write    = w_irw;
    assign bus.pc_en       = w_pcen;
    assign bus.pc_src      = w_pcsrc;
    assign bus.mem_read    = w_mrd;
    assign bus.mem_write   = w_mwr;
    assign bus.reg_write   = w_rw;
    assign bus.mem_to_reg  = w_m2r;
    assign bus.reg_dst     = w_rdst;
    assign bus.halted      = w_halted;
    assign bus.illegal     = r_illegal;
    assign bus.instr_count = r_cnt;
endmodule
